dccm_ctrl: RTL and testbench
============================

# dccm_ctrl

Data closely-coupled memory (DCCM) controller that directly consumes the LSU's DCCM read and write ports. It holds a word-organised 1R1W array and answers LSU reads with a fixed 1-cycle latency. Writes commit at the clock edge. After reset it zero-fills the array with an init state machine. It flags accesses that fall outside its address window.

## Interface
Parameters:
- XLEN, 32, data/address width.
- DCCM_DEPTH, 1024, number of XLEN-bit words; power of two, ≥ 4.
- DCCM_BASE, 32'h0000_0000, byte base address of the window; aligned to DCCM_DEPTH*4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low; one clock, no other clock domains.
- lsu_dccm_raddr  in  XLEN  read byte address; bits [1:0] ignored.
- lsu_dccm_rvalid_in  in  1  read request this cycle.
- lsu_dccm_rdata  out  XLEN  read data, registered.
- lsu_dccm_rvalid_out  out  1  read data valid, 1-cycle pulse per accepted request.
- lsu_dccm_waddr  in  XLEN  write byte address; bits [1:0] ignored.
- lsu_dccm_wen  in  1  write full word this cycle.
- lsu_dccm_wdata  in  XLEN  write data (LSU pre-merges sub-word stores).
- dccm_init_busy  out  1  high while the zero-fill runs; LSU issue must be held off.
- dccm_addr_err  out  1  1-cycle pulse: a read or write in the previous cycle was out of window.

## Operation
- Word index: (addr − DCCM_BASE) >> 2, truncated to $clog2(DCCM_DEPTH) bits.
- In range: (addr − DCCM_BASE) < DCCM_DEPTH*4, unsigned compare, full XLEN width.
- FSM states:
  - INIT: entered on reset; init counter = 0.
    - Each cycle, write 0 to word[counter] and increment the counter.
    - At counter == DCCM_DEPTH−1, go to READY next edge.
  - READY: terminal state.
- During INIT:
  - LSU reads and writes are dropped.
  - rvalid_out = 0, rdata = 0, addr_err = 0.
  - dccm_init_busy = 1.
- READY read, in range: rdata ← word[idx], rvalid_out ← 1.
- READY read, out of range: rdata ← 0, rvalid_out ← 1, addr_err ← 1. The requester always gets a response.
- READY write, in range: word[idx] ← wdata at the edge.
- READY write, out of range: dropped, addr_err ← 1.
- No read request: rvalid_out ← 0; rdata holds its last value.
- Read and write in the same cycle, different words: both are performed.
- Read and write in the same cycle, same word: governed by DCCM_BYPASS_EN (see Configuration).
- Both the read and the write out of range in one cycle: a single addr_err pulse.

## Timing
- Reset values: lsu_dccm_rdata = 0, lsu_dccm_rvalid_out = 0, dccm_init_busy = 1, dccm_addr_err = 0; FSM = INIT, counter = 0.
- Init duration:
  - Exactly DCCM_DEPTH cycles after the first rising edge following rst_n deassertion.
  - dccm_init_busy falls in the cycle the FSM enters READY.
- Reset asserted mid-init or mid-operation: asynchronously returns to INIT with counter 0. The array contents are then rewritten to zero in full.
- Read latency: request in cycle N → rdata and rvalid_out valid in cycle N+1. Back-to-back reads are supported every cycle.
- Write in cycle N, read of the same word in cycle N+1: returns the new data.
- dccm_addr_err: asserted in cycle N+1 for an offending access in cycle N.

## Configuration
- Macro: DCCM_BYPASS_EN.
- Defined: a same-cycle read and write of the same in-range word returns lsu_dccm_wdata (write-first forwarding).
- Undefined: the same read returns the old array content (read-first). The LSU must then not depend on same-cycle forwarding.

## Structure
Shared package dccm_pkg holds:
- dccm_state_e {INIT, READY}.
- Default DCCM_DEPTH and DCCM_BASE constants.
- DCCM_IDX_W = $clog2(DCCM_DEPTH).

XLEN comes from the global header. Sub-module dccm_ram_1r1w is a plain synchronous 1R1W word array with no reset; it is inferable as block RAM. Its write port is muxed between the init FSM and the LSU. The controller owns the FSM, range check, bypass logic and output registers.

## Test plan
- Reset, then idle: dccm_init_busy = 1 for exactly 1024 cycles, then 0. A read of 0x0000_0010 returns 0 with rvalid_out one cycle later.
- Write 0xDEAD_BEEF to 0x0000_0008 (READY); read 0x0000_000A next cycle → rdata = 0xDEAD_BEEF, rvalid_out = 1 one cycle after the request.
- Same-cycle write 0x1234_5678 and read to 0x0000_0020, after a prior value of 0xAAAA_AAAA:
  - DCCM_BYPASS_EN defined → rdata = 0x1234_5678.
  - Undefined → rdata = 0xAAAA_AAAA.
- Read of 0x0000_1000 (depth 1024) → rvalid_out = 1, rdata = 0, addr_err = 1 for one cycle. A write to 0x0000_1000 leaves word 0 unchanged, and addr_err pulses.
- Read issued during INIT at cycle 5 → no rvalid_out. Reset pulsed at init cycle 500 → dccm_init_busy stays high a further 1024 cycles.
- Reads every cycle to 0x0, 0x4, 0x8, 0xC preloaded with 1, 2, 3, 4 → rvalid_out high for 4 consecutive cycles with rdata 1, 2, 3, 4.

Source files
------------

// File: rtl/dccm_pkg.sv
// Shared types and default constants for the DCCM controller slice.
package dccm_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } dccm_state_e;

  localparam int          DCCM_XLEN_DEFAULT  = 32;
  localparam int          DCCM_DEPTH_DEFAULT = 1024;
  localparam logic [31:0] DCCM_BASE_DEFAULT  = 32'h0000_0000;
  localparam int          DCCM_IDX_W         = $clog2(DCCM_DEPTH_DEFAULT);

endpackage

// File: rtl/dccm_ram_1r1w.sv
// Plain synchronous 1R1W word array, no reset, written so it maps onto block RAM.
// A same-edge read of the word being written returns the old content.
module dccm_ram_1r1w
  import dccm_pkg::*;
#(
  parameter int WIDTH = DCCM_XLEN_DEFAULT,
  parameter int DEPTH = DCCM_DEPTH_DEFAULT,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dccm_ctrl.sv
// DCCM controller: zero-fill init FSM, window check, 1-cycle LSU reads, edge-committed writes.
// Optional macro DCCM_BYPASS_EN selects write-first forwarding for same-cycle same-word read/write.
module dccm_ctrl
  import dccm_pkg::*;
#(
  parameter int              XLEN       = DCCM_XLEN_DEFAULT,
  parameter int              DCCM_DEPTH = DCCM_DEPTH_DEFAULT,
  parameter logic [XLEN-1:0] DCCM_BASE  = XLEN'(DCCM_BASE_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lsu_dccm_raddr,
  input  logic            lsu_dccm_rvalid_in,
  output logic [XLEN-1:0] lsu_dccm_rdata,
  output logic            lsu_dccm_rvalid_out,
  input  logic [XLEN-1:0] lsu_dccm_waddr,
  input  logic            lsu_dccm_wen,
  input  logic [XLEN-1:0] lsu_dccm_wdata,
  output logic            dccm_init_busy,
  output logic            dccm_addr_err
);

  localparam int               IDX_W     = $clog2(DCCM_DEPTH);
  localparam logic [XLEN-1:0]  WIN_BYTES = XLEN'(DCCM_DEPTH * 4);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DCCM_DEPTH - 1);
  localparam logic [0:0]       S_INIT    = 1'(INIT);
  localparam logic [0:0]       S_READY   = 1'(READY);

  logic [0:0]       state;
  logic [IDX_W-1:0] init_cnt;
  logic             ready;
  logic [XLEN-1:0]  roff;
  logic [XLEN-1:0]  woff;
  logic             r_in;
  logic             w_in;
  logic [IDX_W-1:0] ridx;
  logic [IDX_W-1:0] widx;
  logic             rd_acc;
  logic             wr_acc;
  logic             ram_we;
  logic [IDX_W-1:0] ram_waddr;
  logic [XLEN-1:0]  ram_wdata;
  logic [XLEN-1:0]  ram_q;
  logic [XLEN-1:0]  rd_word;
  logic             rd_hit;
  logic [XLEN-1:0]  hold_q;

  assign ready  = (state == S_READY);
  assign roff   = lsu_dccm_raddr - DCCM_BASE;
  assign woff   = lsu_dccm_waddr - DCCM_BASE;
  assign r_in   = (roff < WIN_BYTES);
  assign w_in   = (woff < WIN_BYTES);
  assign ridx   = roff[IDX_W+1:2];
  assign widx   = woff[IDX_W+1:2];
  assign rd_acc = ready & lsu_dccm_rvalid_in & r_in;
  assign wr_acc = ready & lsu_dccm_wen & w_in;

  // The init FSM owns the write port until every word has been cleared.
  assign ram_we    = ~ready | wr_acc;
  assign ram_waddr = ready ? widx : init_cnt;
  assign ram_wdata = ready ? lsu_dccm_wdata : '0;

  dccm_ram_1r1w #(
    .WIDTH(XLEN),
    .DEPTH(DCCM_DEPTH),
    .IDX_W(IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (rd_acc),
    .raddr(ridx),
    .rdata(ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else if (!ready) begin
      init_cnt <= init_cnt + IDX_W'(1);
      if (init_cnt == LAST_IDX) state <= S_READY;
    end
  end

  // hold_q tracks what the LSU currently sees so rdata is stable across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsu_dccm_rvalid_out <= 1'b0;
      dccm_addr_err       <= 1'b0;
      rd_hit              <= 1'b0;
      hold_q              <= '0;
    end else begin
      lsu_dccm_rvalid_out <= ready & lsu_dccm_rvalid_in;
      dccm_addr_err       <= ready & ((lsu_dccm_rvalid_in & ~r_in) | (lsu_dccm_wen & ~w_in));
      rd_hit              <= rd_acc;
      if (ready & lsu_dccm_rvalid_in & ~r_in) hold_q <= '0;
      else                                    hold_q <= lsu_dccm_rdata;
    end
  end

`ifdef DCCM_BYPASS_EN
  logic            byp_q;
  logic [XLEN-1:0] byp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q    <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_q <= rd_acc & wr_acc & (ridx == widx);
      if (rd_acc) byp_data <= lsu_dccm_wdata;
    end
  end

  assign rd_word = byp_q ? byp_data : ram_q;
`else
  assign rd_word = ram_q;
`endif

  assign lsu_dccm_rdata = rd_hit ? rd_word : hold_q;
  assign dccm_init_busy = ~ready;

endmodule

// File: tb/tb_dccm_ctrl.sv
// Self-checking bench for dccm_ctrl against an array-based reference model.
// Follows DCCM_BYPASS_EN the same way the design does.
module tb_dccm_ctrl;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] WIN   = 32'(DEPTH * 4);

  logic        clk;
  logic        rst_n;
  logic [31:0] raddr;
  logic        rvalid_in;
  logic [31:0] rdata;
  logic        rvalid_out;
  logic [31:0] waddr;
  logic        wen;
  logic [31:0] wdata;
  logic        init_busy;
  logic        addr_err;

  int total;
  int bad;

  logic [31:0] mem_model [DEPTH];
  logic [31:0] last_rdata;
  logic [33:0] exp_v;
  logic [33:0] obs;

  dccm_ctrl #(
    .XLEN      (32),
    .DCCM_DEPTH(DEPTH),
    .DCCM_BASE (32'h0000_0000)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .lsu_dccm_raddr     (raddr),
    .lsu_dccm_rvalid_in (rvalid_in),
    .lsu_dccm_rdata     (rdata),
    .lsu_dccm_rvalid_out(rvalid_out),
    .lsu_dccm_waddr     (waddr),
    .lsu_dccm_wen       (wen),
    .lsu_dccm_wdata     (wdata),
    .dccm_init_busy     (init_busy),
    .dccm_addr_err      (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
    last_rdata = '0;
  endtask

  // Predicts {rvalid_out, addr_err, rdata} for one access, then commits the write.
  task automatic model_access(input logic rv, input logic [31:0] ra, input logic we,
                              input logic [31:0] wa, input logic [31:0] wd);
    logic        r_ok;
    logic        w_ok;
    int          ri;
    int          wi;
    logic [31:0] rd;
    r_ok = (ra < WIN);
    w_ok = (wa < WIN);
    ri   = int'(ra / 4) % DEPTH;
    wi   = int'(wa / 4) % DEPTH;
    rd   = last_rdata;
    if (rv) begin
      if (r_ok) begin
        rd = mem_model[ri];
`ifdef DCCM_BYPASS_EN
        if (we && w_ok && wi == ri) rd = wd;
`endif
      end else begin
        rd = '0;
      end
    end
    exp_v      = {rv, (rv && !r_ok) || (we && !w_ok), rd};
    last_rdata = rd;
    if (we && w_ok) mem_model[wi] = wd;
  endtask

  task automatic step(input logic rv, input logic [31:0] ra, input logic we,
                      input logic [31:0] wa, input logic [31:0] wd);
    rvalid_in = rv;
    raddr     = ra;
    wen       = we;
    waddr     = wa;
    wdata     = wd;
    @(posedge clk);
    #1;
    rvalid_in = 1'b0;
    wen       = 1'b0;
    obs       = {rvalid_out, addr_err, rdata};
  endtask

  task automatic do_reset(input string tag);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    rvalid_in = 1'b0;
    wen       = 1'b0;
    rst_n     = 1'b0;
    #3;
    rst_n = 1'b1;
    model_clear();
    while (init_busy === 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n != DEPTH) begin
      bad++;
      $display("[TB] FAIL %s_init_len got=%0d exp=%0d", tag, n, DEPTH);
    end
    total++;
  endtask

  task automatic test_reset();
    int   n;
    logic seen_rv;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if ({init_busy, rvalid_out, addr_err, rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      bad++;
      $display("[TB] FAIL reset_values got=%h exp=%h",
               {init_busy, rvalid_out, addr_err, rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
    end
    total++;
    rst_n   = 1'b1;
    n       = 0;
    seen_rv = 1'b0;
    while (init_busy === 1'b1 && n < 3000) begin
      rvalid_in = (n == 5);
      raddr     = 32'h0000_0004;
      @(posedge clk);
      #1;
      n++;
      if (rvalid_out !== 1'b0 || addr_err !== 1'b0) seen_rv = 1'b1;
    end
    rvalid_in = 1'b0;
    if (seen_rv !== 1'b0) begin
      bad++;
      $display("[TB] FAIL init_read_dropped got=%b exp=0", seen_rv);
    end
    total++;
    if (n != DEPTH) begin
      bad++;
      $display("[TB] FAIL init_len got=%0d exp=%0d", n, DEPTH);
    end
    total++;
    model_clear();
  endtask

  task automatic test_zero_fill();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0000_0010;
    addrs[1] = 32'h0000_0FFC;
    addrs[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      model_access(1'b1, addrs[i], 1'b0, 32'h0, 32'h0);
      step(1'b1, addrs[i], 1'b0, 32'h0, 32'h0);
      if (obs !== exp_v) begin
        bad++;
        $display("[TB] FAIL zero_fill[%0d] got=%h exp=%h", i, obs, exp_v);
      end
      total++;
    end
  endtask

  task automatic test_write_read();
    model_access(1'b0, 32'h0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    step(1'b0, 32'h0, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    model_access(1'b1, 32'h0000_000A, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0000_000A, 1'b0, 32'h0, 32'h0);
    if (obs !== exp_v) begin
      bad++;
      $display("[TB] FAIL write_read got=%h exp=%h", obs, exp_v);
    end
    total++;
    model_access(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    if (obs !== exp_v) begin
      bad++;
      $display("[TB] FAIL rdata_hold got=%h exp=%h", obs, exp_v);
    end
    total++;
  endtask

  task automatic test_same_cycle();
    model_access(1'b0, 32'h0, 1'b1, 32'h0000_0020, 32'hAAAA_AAAA);
    step(1'b0, 32'h0, 1'b1, 32'h0000_0020, 32'hAAAA_AAAA);
    model_access(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0020, 32'h1234_5678);
    step(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0020, 32'h1234_5678);
    if (obs !== exp_v) begin
      bad++;
      $display("[TB] FAIL same_cycle got=%h exp=%h", obs, exp_v);
    end
    total++;
    model_access(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0040, 32'h0BAD_F00D);
    step(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0040, 32'h0BAD_F00D);
    if (obs !== exp_v) begin
      bad++;
      $display("[TB] FAIL same_cycle_diff got=%h exp=%h", obs, exp_v);
    end
    total++;
    model_access(1'b1, 32'h0000_0040, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0000_0040, 1'b0, 32'h0, 32'h0);
    if (obs !== exp_v) begin
      bad++;
      $display("[TB] FAIL same_cycle_after got=%h exp=%h", obs, exp_v);
    end
    total++;
  endtask

  task automatic test_out_of_range();
    logic        rv [7];
    logic [31:0] ra [7];
    logic        we [7];
    logic [31:0] wa [7];
    logic [31:0] wd [7];
    rv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ra = '{32'h0, 32'h0000_1000, 32'h0, 32'h0, 32'h0, 32'h0000_2000, 32'h0};
    we = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    wa = '{32'h0, 32'h0, 32'h0, 32'h0000_1000, 32'h0, 32'hFFFF_FFF0, 32'h0};
    wd = '{32'h0000_0077, 32'h0, 32'h0, 32'h0000_0099, 32'h0, 32'h5555_5555, 32'h0};
    for (int i = 0; i < 7; i++) begin
      model_access(rv[i], ra[i], we[i], wa[i], wd[i]);
      step(rv[i], ra[i], we[i], wa[i], wd[i]);
      if (obs !== exp_v) begin
        bad++;
        $display("[TB] FAIL out_of_range[%0d] got=%h exp=%h", i, obs, exp_v);
      end
      total++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      model_access(1'b0, 32'h0, 1'b1, 32'(i * 4), 32'(i + 1));
      step(1'b0, 32'h0, 1'b1, 32'(i * 4), 32'(i + 1));
    end
    for (int i = 0; i < 4; i++) begin
      model_access(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'(i * 4), 1'b0, 32'h0, 32'h0);
      if (obs !== exp_v) begin
        bad++;
        $display("[TB] FAIL back_to_back[%0d] got=%h exp=%h", i, obs, exp_v);
      end
      total++;
    end
  endtask

  task automatic test_random();
    logic        rv;
    logic [31:0] ra;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    for (int i = 0; i < 400; i++) begin
      rv = 1'($urandom_range(0, 1));
      ra = 32'($urandom_range(0, DEPTH * 4 + 255));
      we = 1'($urandom_range(0, 1));
      wa = ($urandom_range(0, 3) == 0) ? ra : 32'($urandom_range(0, DEPTH * 4 + 255));
      wd = $urandom;
      model_access(rv, ra, we, wa, wd);
      step(rv, ra, we, wa, wd);
      if (obs !== exp_v) begin
        bad++;
        $display("[TB] FAIL random[%0d] got=%h exp=%h", i, obs, exp_v);
      end
      total++;
    end
  endtask

  task automatic test_reset_clears();
    model_access(1'b0, 32'h0, 1'b1, 32'h0000_000C, 32'h0000_0055);
    step(1'b0, 32'h0, 1'b1, 32'h0000_000C, 32'h0000_0055);
    model_access(1'b1, 32'h0000_000C, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0000_000C, 1'b0, 32'h0, 32'h0);
    do_reset("mid_op");
    model_access(1'b1, 32'h0000_000C, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0000_000C, 1'b0, 32'h0, 32'h0);
    if (obs !== exp_v) begin
      bad++;
      $display("[TB] FAIL reset_clears got=%h exp=%h", obs, exp_v);
    end
    total++;
  endtask

  task automatic test_reset_mid_init();
    int n;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    if ({init_busy, rvalid_out, rdata} !== {1'b1, 1'b0, 32'h0}) begin
      bad++;
      $display("[TB] FAIL mid_init_reset_vals got=%h exp=%h",
               {init_busy, rvalid_out, rdata}, {1'b1, 1'b0, 32'h0});
    end
    total++;
    rst_n = 1'b1;
    n     = 0;
    while (init_busy === 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n != DEPTH) begin
      bad++;
      $display("[TB] FAIL mid_init_len got=%0d exp=%0d", n, DEPTH);
    end
    total++;
    model_clear();
    model_access(1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0000_0008, 1'b0, 32'h0, 32'h0);
    if (obs !== exp_v) begin
      bad++;
      $display("[TB] FAIL mid_init_zero got=%h exp=%h", obs, exp_v);
    end
    total++;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    raddr     = '0;
    rvalid_in = 1'b0;
    waddr     = '0;
    wen       = 1'b0;
    wdata     = '0;
    model_clear();
    $display("[TB] starting dccm_ctrl bench");
    test_reset();
    test_zero_fill();
    test_write_read();
    test_same_cycle();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_clears();
    test_reset_mid_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
